// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: next-PC source encoding
// and the instruction-alignment mask helper.
package pc_pkg;

    typedef enum logic [2:0] {
        SEL_SEQ  = 3'd0,
        SEL_BR   = 3'd1,
        SEL_JMP  = 3'd2,
        SEL_RET  = 3'd3,
        SEL_RETF = 3'd4,
        SEL_EXC  = 3'd5
    } sel_e;

    // Low-bit mask covering the byte offset inside one instruction.
    function automatic logic [63:0] align_mask(input int unsigned bytes);
        return 64'(bytes) - 64'd1;
    endfunction

endpackage

// File: rtl/return_stack.sv
// Circular return-address stack with top pointer and occupancy count;
// a push into a full stack overwrites the oldest entry and sets a sticky flag.
module return_stack #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full,
    output logic             overflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(RAS_DEPTH);

    logic [WIDTH-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0] ptr, ptr_pop, ptr_next;
    logic [PTR_W:0]   cnt, cnt_pop, cnt_next;
    logic             do_pop;

    // Pop is applied first, then push, so a simultaneous pop+push replaces the top.
    always_comb begin
        do_pop   = pop && (cnt != '0);
        ptr_pop  = do_pop ? ptr - PTR_W'(1) : ptr;
        cnt_pop  = do_pop ? cnt - (PTR_W + 1)'(1) : cnt;
        ptr_next = ptr_pop;
        cnt_next = cnt_pop;
        if (push) begin
            ptr_next = ptr_pop + PTR_W'(1);
            if (cnt_pop != DEPTH_C) begin
                cnt_next = cnt_pop + (PTR_W + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr      <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            ptr <= ptr_next;
            cnt <= cnt_next;
            if (push && (cnt_pop == DEPTH_C)) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[ptr_next] <= push_data;
        end
    end

    assign top   = mem[ptr];
    assign empty = (cnt == '0);
    assign full  = (cnt == DEPTH_C);

endmodule

// File: rtl/pc_unit.sv
// Program counter with internal sequential adder, prioritised next-PC
// selection, stall, exception entry and return-address-stack redirection.
module pc_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter int               INSTR_BYTES  = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h00000000),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h80000180),
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             exc,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic             call,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             ret,
    input  logic [WIDTH-1:0] ret_target,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus,
    output logic             misaligned,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_overflow
);

    localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(align_mask(INSTR_BYTES));
    localparam logic [WIDTH-1:0] STEP     = WIDTH'(INSTR_BYTES);

    sel_e             sel;
    logic             hold;
    logic [WIDTH-1:0] raw_target;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] ras_top;
    logic             push;
    logic             pop;

    assign pc_plus = pc + STEP;

    // A call wins over a simultaneous ret: the ret only pops the stack.
    always_comb begin
        hold = 1'b0;
        sel  = SEL_SEQ;
        if (exc) begin
            sel = SEL_EXC;
        end else if (stall) begin
            hold = 1'b1;
        end else if (ret && !call) begin
            sel = ras_empty ? SEL_RETF : SEL_RET;
        end else if (call || jump) begin
            sel = SEL_JMP;
        end else if (branch_taken) begin
            sel = SEL_BR;
        end

        case (sel)
            SEL_EXC:  raw_target = EXC_VECTOR;
            SEL_RET:  raw_target = ras_top;
            SEL_RETF: raw_target = ret_target;
            SEL_JMP:  raw_target = jump_target;
            SEL_BR:   raw_target = branch_target;
            default:  raw_target = pc_plus;
        endcase

        pc_next    = (sel == SEL_SEQ) ? pc_plus : (raw_target & ~LOW_MASK);
        misaligned = (sel != SEL_SEQ) && ((raw_target & LOW_MASK) != '0);
    end

    assign push = call && !exc && !stall;
    assign pop  = ret && !exc && !stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_VECTOR;
        end else if (!hold) begin
            pc <= pc_next;
        end
    end

    return_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (pc_plus),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .overflow  (ras_overflow)
    );

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: queue-based reference model checked every cycle plus
// directed scenarios with literal expected PC and stack-flag values.
module tb_pc_unit;

    localparam logic [31:0] EXC_V = 32'h80000180;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0, exc = 1'b0, branch_taken = 1'b0;
    logic        jump = 1'b0, call = 1'b0, ret = 1'b0;
    logic [31:0] branch_target = '0, jump_target = '0, ret_target = '0;
    logic [31:0] pc, pc_plus;
    logic        misaligned, ras_empty, ras_full, ras_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_pc  = 32'h0;
    logic [31:0] m_ras[$];
    bit          m_ovf = 1'b0;

    pc_unit dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .exc           (exc),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .call          (call),
        .jump_target   (jump_target),
        .ret           (ret),
        .ret_target    (ret_target),
        .pc            (pc),
        .pc_plus       (pc_plus),
        .misaligned    (misaligned),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full),
        .ras_overflow  (ras_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, got, exp);
        end
    endtask

    // Reference model: the stack is a queue, newest entry at the back.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pc = 32'h0;
            m_ras.delete();
            m_ovf = 1'b0;
        end else if (exc) begin
            m_pc = EXC_V;
        end else if (!stall) begin
            if (call) begin
                if (ret && m_ras.size() > 0) void'(m_ras.pop_back());
                if (m_ras.size() == DEPTH) begin
                    void'(m_ras.pop_front());
                    m_ovf = 1'b1;
                end
                m_ras.push_back(m_pc + 32'd4);
                m_pc = {jump_target[31:2], 2'b00};
            end else if (ret) begin
                if (m_ras.size() > 0) m_pc = m_ras.pop_back();
                else m_pc = {ret_target[31:2], 2'b00};
            end else if (jump) begin
                m_pc = {jump_target[31:2], 2'b00};
            end else if (branch_taken) begin
                m_pc = {branch_target[31:2], 2'b00};
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
    end

    function automatic logic exp_mis();
        if (exc || stall) return 1'b0;
        if (ret && !call) return (m_ras.size() == 0) && (ret_target[1:0] != 2'b00);
        if (call || jump) return jump_target[1:0] != 2'b00;
        if (branch_taken) return branch_target[1:0] != 2'b00;
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        chk("model_pc", pc, m_pc);
        chk("model_pc_plus", pc_plus, m_pc + 32'd4);
        chk("model_misaligned", {31'b0, misaligned}, {31'b0, exp_mis()});
        chk("model_ras_empty", {31'b0, ras_empty}, {31'b0, m_ras.size() == 0});
        chk("model_ras_full", {31'b0, ras_full}, {31'b0, m_ras.size() == DEPTH});
        chk("model_ras_overflow", {31'b0, ras_overflow}, {31'b0, m_ovf});
    end

    task automatic drive(input logic s, input logic e, input logic b, input logic j,
                         input logic c, input logic r, input logic [31:0] bt,
                         input logic [31:0] jt, input logic [31:0] rt);
        stall = s; exc = e; branch_taken = b; jump = j; call = c; ret = r;
        branch_target = bt; jump_target = jt; ret_target = rt;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic step(input logic s, input logic e, input logic b, input logic j,
                        input logic c, input logic r, input logic [31:0] bt,
                        input logic [31:0] jt, input logic [31:0] rt);
        drive(s, e, b, j, c, r, bt, jt, rt);
        tick();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic pulse_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        chk("async_reset_pc", pc, 32'h0);
        chk("async_reset_empty", {31'b0, ras_empty}, 32'd1);
        chk("async_reset_ovf", {31'b0, ras_overflow}, 32'd0);
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        chk("reset_pc", pc, 32'h0);
        chk("reset_empty", {31'b0, ras_empty}, 32'd1);
        chk("reset_full", {31'b0, ras_full}, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        chk("pc0", pc, 32'h0);
        idle(); chk("pc4", pc, 32'h4); chk("pc_plus8", pc_plus, 32'h8);
        idle(); chk("pc8", pc, 32'h8);
        idle(); chk("pcC", pc, 32'hC); chk("model_pin_C", m_pc, 32'hC);

        pulse_reset();
        idle(); idle(); chk("pc8_again", pc, 32'h8);
        step(1, 0, 1, 0, 0, 0, 32'h300, 0, 0); chk("stall1", pc, 32'h8);
        step(1, 0, 1, 0, 0, 0, 32'h300, 0, 0); chk("stall2", pc, 32'h8);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0); chk("exc_over_stall", pc, EXC_V);

        drive(0, 0, 1, 0, 0, 0, 32'h103, 0, 0);
        #1;
        chk("misaligned_br", {31'b0, misaligned}, 32'd1);
        tick(); chk("br_aligned", pc, 32'h100);
        step(0, 0, 1, 1, 0, 0, 32'h300, 32'h200, 0); chk("jump_over_br", pc, 32'h200);

        pulse_reset();
        repeat (4) idle();
        chk("pc10", pc, 32'h10);
        step(0, 0, 0, 0, 1, 0, 0, 32'h400, 0); chk("call_pc", pc, 32'h400);
        chk("call_not_empty", {31'b0, ras_empty}, 32'd0);
        idle(); chk("pc404", pc, 32'h404);
        step(0, 0, 0, 0, 0, 1, 0, 0, 32'h999); chk("ret_pc", pc, 32'h14);
        chk("ret_empty", {31'b0, ras_empty}, 32'd1);

        pulse_reset();
        for (int i = 1; i <= 5; i++) begin
            step(0, 0, 0, 0, 1, 0, 0, 32'(i) * 32'h100, 0);
            if (i == 4) chk("ras_full4", {31'b0, ras_full}, 32'd1);
        end
        chk("calls_pc", pc, 32'h500);
        chk("ovf_full", {31'b0, ras_full}, 32'd1);
        chk("ovf_flag", {31'b0, ras_overflow}, 32'd1);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0); chk("ret1", pc, 32'h404);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0); chk("ret2", pc, 32'h304);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0); chk("ret3", pc, 32'h204);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0); chk("ret4", pc, 32'h104);
        chk("ret4_empty", {31'b0, ras_empty}, 32'd1);
        chk("ovf_sticky", {31'b0, ras_overflow}, 32'd1);
        step(0, 0, 0, 0, 0, 1, 0, 0, 32'h50); chk("ret5_fallback", pc, 32'h50);

        step(0, 0, 0, 1, 0, 0, 0, 32'hFFFFFFFC, 0); chk("pc_top", pc, 32'hFFFFFFFC);
        chk("pc_plus_wrap", pc_plus, 32'h0);
        idle(); chk("pc_wrap", pc, 32'h0);

        pulse_reset();
        step(0, 0, 0, 1, 0, 0, 0, 32'h40, 0); chk("jmp40", pc, 32'h40);
        step(0, 0, 0, 0, 1, 0, 0, 32'h60, 0); chk("call60", pc, 32'h60);
        step(0, 0, 0, 0, 1, 1, 0, 32'h800, 32'h999); chk("callret_pc", pc, 32'h800);
        chk("callret_not_empty", {31'b0, ras_empty}, 32'd0);
        step(0, 0, 0, 0, 0, 1, 0, 0, 32'h999); chk("callret_top", pc, 32'h64);
        chk("callret_count", {31'b0, ras_empty}, 32'd1);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
